// File: rtl/twf_gen.sv
// Twiddle-factor generator: constant cos/sin ROM, two-stage pipeline
// with backpressure, plus an automatic group sweep FSM.
module twf_gen #(
    parameter int LANES    = 16,
    parameter int WIDTH    = 9,
    parameter int GRP_BITS = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    input  logic [GRP_BITS-1:0]                 req_grp,
    input  logic                                req_inv,
    output logic                                req_ready,
    input  logic                                start,
    input  logic                                start_inv,
    output logic                                busy,
    output logic                                done,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [GRP_BITS-1:0]                 out_grp,
    output logic signed [LANES-1:0][WIDTH-1:0]  re,
    output logic signed [LANES-1:0][WIDTH-1:0]  im
);

    localparam int     NUM_GRP = 2 ** GRP_BITS;
    localparam int     NPTS    = 2 * NUM_GRP * LANES;
    localparam longint ONE     = 64'sd1073741824;
    localparam longint HALF    = 64'sd536870912;
    localparam longint PIH     = 64'sd1686629713;
    localparam longint SCALE   = 64'sd1 << (WIDTH - 2);
    localparam logic [GRP_BITS-1:0] LAST = GRP_BITS'(NUM_GRP - 1);

    // Q30 fixed-point Taylor evaluation over one quadrant, then
    // quadrant folding and round-half-away-from-zero scaling.
    function automatic logic signed [WIDTH-1:0] twf_val(
        input int   a,
        input logic want_im
    );
        longint x, x2, t, sn, cs, c, s, v, p, r;
        int     q, rem;
        q   = (4 * a) / NPTS;
        rem = (4 * a) % NPTS;
        x   = (PIH * longint'(rem)) / longint'(NPTS);
        x2  = (x * x) >>> 30;
        sn  = 0;
        cs  = 0;
        t   = x;
        for (int k = 1; k < 20; k += 2) begin
            sn += t;
            t = -(((t * x2) >>> 30) / longint'((k + 1) * (k + 2)));
        end
        t = ONE;
        for (int k = 0; k < 20; k += 2) begin
            cs += t;
            t = -(((t * x2) >>> 30) / longint'((k + 1) * (k + 2)));
        end
        if (q == 0) begin
            c = cs;
            s = sn;
        end else if (q == 1) begin
            c = -sn;
            s = cs;
        end else if (q == 2) begin
            c = -cs;
            s = -sn;
        end else begin
            c = sn;
            s = -cs;
        end
        v = want_im ? -s : c;
        p = v * SCALE;
        r = (p >= 0) ? ((p + HALF) >>> 30) : -((HALF - p) >>> 30);
        return WIDTH'(r);
    endfunction

    logic signed [WIDTH-1:0] rom_re [NUM_GRP][LANES];
    logic signed [WIDTH-1:0] rom_im [NUM_GRP][LANES];

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            localparam logic signed [WIDTH-1:0] RV = twf_val(g * LANES + l, 1'b0);
            localparam logic signed [WIDTH-1:0] IV = twf_val(g * LANES + l, 1'b1);
            assign rom_re[g][l] = RV;
            assign rom_im[g][l] = IV;
        end
    end

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t              state;
    logic [GRP_BITS-1:0] cnt;
    logic                sweep_inv;
    logic                s1_valid;
    logic [GRP_BITS-1:0] s1_grp;
    logic                s1_inv;
    logic                s1_last;
    logic                s2_last;
    logic                s2_can;
    logic                pipe_ready;
    logic                ext_fire;
    logic                int_fire;
    logic                start_ok;
    logic                last_accept;

    assign s2_can      = !out_valid || out_ready;
    assign pipe_ready  = !s1_valid || s2_can;
    assign req_ready   = !rst && (state == IDLE) && pipe_ready && !start;
    assign ext_fire    = req_valid && req_ready;
    assign int_fire    = (state == SWEEP) && pipe_ready;
    assign start_ok    = start && (state == IDLE) && !busy;
    assign last_accept = out_valid && out_ready && s2_last;

    // Stage 1: capture the group, conjugate flag and last-beat tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_grp   <= '0;
            s1_inv   <= 1'b0;
            s1_last  <= 1'b0;
        end else if (pipe_ready) begin
            s1_valid <= ext_fire || int_fire;
            s1_grp   <= int_fire ? cnt : req_grp;
            s1_inv   <= int_fire ? sweep_inv : req_inv;
            s1_last  <= int_fire && (cnt == LAST);
        end
    end

    // Stage 2: ROM lookup with optional conjugation; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s2_last   <= 1'b0;
            out_grp   <= '0;
            re        <= '0;
            im        <= '0;
        end else if (s2_can) begin
            out_valid <= s1_valid;
            s2_last   <= s1_valid && s1_last;
            if (s1_valid) begin
                out_grp <= s1_grp;
                for (int l = 0; l < LANES; l++) begin
                    re[l] <= rom_re[s1_grp][l];
                    im[l] <= s1_inv ? -rom_im[s1_grp][l] : rom_im[s1_grp][l];
                end
            end
        end
    end

    // Sweep controller: issues groups 0..NUM_GRP-1, then waits for the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sweep_inv <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start_ok) begin
                        state     <= SWEEP;
                        cnt       <= '0;
                        sweep_inv <= start_inv;
                        busy      <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (int_fire) begin
                        if (cnt == LAST) begin
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twf_gen.sv
// Bench for twf_gen: scoreboard of expected beats against a
// floating-point cos/sin model, one task per scenario.
`timescale 1ns/1ps
module tb_twf_gen;

    localparam int  LANES    = 16;
    localparam int  WIDTH    = 9;
    localparam int  GRP_BITS = 5;
    localparam int  NUM_GRP  = 1 << GRP_BITS;
    localparam int  NPTS     = 2 * NUM_GRP * LANES;
    localparam real S        = real'(1 << (WIDTH - 2));
    localparam real PI       = 3.14159265358979323846;

    logic                               clk = 1'b0;
    logic                               rst = 1'b1;
    logic                               req_valid = 1'b0;
    logic [GRP_BITS-1:0]                req_grp = '0;
    logic                               req_inv = 1'b0;
    logic                               req_ready;
    logic                               start = 1'b0;
    logic                               start_inv = 1'b0;
    logic                               busy;
    logic                               done;
    logic                               out_valid;
    logic                               out_ready = 1'b1;
    logic [GRP_BITS-1:0]                out_grp;
    logic signed [LANES-1:0][WIDTH-1:0] re;
    logic signed [LANES-1:0][WIDTH-1:0] im;

    typedef struct packed {
        logic [GRP_BITS-1:0] grp;
        logic                inv;
    } exp_t;

    typedef struct packed {
        logic [GRP_BITS-1:0]          grp;
        logic [LANES-1:0][WIDTH-1:0]  re;
        logic [LANES-1:0][WIDTH-1:0]  im;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    twf_gen #(
        .LANES(LANES),
        .WIDTH(WIDTH),
        .GRP_BITS(GRP_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_grp(req_grp),
        .req_inv(req_inv),
        .req_ready(req_ready),
        .start(start),
        .start_inv(start_inv),
        .busy(busy),
        .done(done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_grp(out_grp),
        .re(re),
        .im(im)
    );

    // Record accepted requests and accepted output beats.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready)
            exp_q.push_back('{grp: req_grp, inv: req_inv});
        if (!rst && out_valid && out_ready)
            obs_q.push_back('{grp: out_grp, re: re, im: im});
    end

    function automatic int m_rnd(real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int m_re(int g, int l);
        real th;
        th = 2.0 * PI * real'(g * LANES + l) / real'(NPTS);
        return m_rnd(S * $cos(th));
    endfunction

    function automatic int m_im(int g, int l, logic inv);
        real th;
        int  v;
        th = 2.0 * PI * real'(g * LANES + l) / real'(NPTS);
        v  = -m_rnd(S * $sin(th));
        return inv ? -v : v;
    endfunction

    function automatic int lane_diff(exp_t e, obs_t o);
        int bad;
        bad = -1;
        for (int l = LANES - 1; l >= 0; l--)
            if ($signed(o.re[l]) !== m_re(int'(e.grp), l) ||
                $signed(o.im[l]) !== m_im(int'(e.grp), l, e.inv))
                bad = l;
        return bad;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_valid, busy, done, req_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got v/b/d/r %b%b%b%b, required 0000",
                     out_valid, busy, done, req_ready);
        end
        n_tests++;
        if (out_grp !== '0 || re !== '0 || im !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got grp %0d re %h im %h, required 0",
                     out_grp, re, im);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got req_ready %b, required 1", req_ready);
        end
    endtask

    task automatic test_single();
        exp_t e;
        obs_t o;
        int   b;
        int   bl;
        out_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b1;
        req_grp = '0;
        req_inv = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: got req_ready %b, required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_lat1: got out_valid %b, required 0", out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_grp !== '0 ||
            $signed(re[0]) !== 128 || $signed(im[0]) !== 0 ||
            $signed(re[1]) !== 128 || $signed(im[1]) !== -1) begin
            n_fail++;
            $display("FAIL single_lat2: got v %b grp %0d re0 %0d im0 %0d re1 %0d im1 %0d, required 1 0 128 0 128 -1",
                     out_valid, out_grp, $signed(re[0]), $signed(im[0]),
                     $signed(re[1]), $signed(im[1]));
        end
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_count: got %0d beats, required %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e  = exp_q.pop_front();
            o  = obs_q.pop_front();
            b  = lane_diff(e, o);
            bl = (b < 0) ? 0 : b;
            n_tests++;
            if (o.grp !== e.grp || b >= 0) begin
                n_fail++;
                $display("FAIL single_beat: got grp %0d lane %0d re %0d im %0d, required grp %0d re %0d im %0d",
                         o.grp, bl, $signed(o.re[bl]), $signed(o.im[bl]), e.grp,
                         m_re(int'(e.grp), bl), m_im(int'(e.grp), bl, e.inv));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_quarter();
        exp_t e;
        obs_t o;
        int   b;
        int   bl;
        out_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b1;
        req_grp = GRP_BITS'(16);
        req_inv = 1'b0;
        @(posedge clk);
        #1 req_inv = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_inv = 1'b0;
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_q.size() < 2 ||
            $signed(obs_q[0].re[0]) !== 0 || $signed(obs_q[0].im[0]) !== -128) begin
            n_fail++;
            $display("FAIL quarter_fwd: got %0d beats re0 %0d im0 %0d, required re0 0 im0 -128",
                     obs_q.size(), $signed(obs_q[0].re[0]), $signed(obs_q[0].im[0]));
        end
        n_tests++;
        if (obs_q.size() < 2 ||
            $signed(obs_q[1].re[0]) !== 0 || $signed(obs_q[1].im[0]) !== 128) begin
            n_fail++;
            $display("FAIL quarter_inv: got %0d beats re0 %0d im0 %0d, required re0 0 im0 128",
                     obs_q.size(), $signed(obs_q[1].re[0]), $signed(obs_q[1].im[0]));
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL quarter_count: got %0d beats, required %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e  = exp_q.pop_front();
            o  = obs_q.pop_front();
            b  = lane_diff(e, o);
            bl = (b < 0) ? 0 : b;
            n_tests++;
            if (o.grp !== e.grp || b >= 0) begin
                n_fail++;
                $display("FAIL quarter_beat: got grp %0d lane %0d re %0d im %0d, required grp %0d re %0d im %0d",
                         o.grp, bl, $signed(o.re[bl]), $signed(o.im[bl]), e.grp,
                         m_re(int'(e.grp), bl), m_im(int'(e.grp), bl, e.inv));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t o;
        int   b;
        int   bl;
        out_ready = 1'b0;
        fork
            begin
                int t;
                for (int k = 3; k <= 5; k++) begin
                    @(posedge clk);
                    #1 req_valid = 1'b1;
                    req_grp = GRP_BITS'(k);
                    req_inv = 1'b0;
                    t = 0;
                    @(negedge clk);
                    while (!req_ready && t < 40) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 40) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL b2b_req_timeout: grp %0d got no req_ready, required 1", k);
                    end
                end
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
            begin
                int   w;
                obs_t snap;
                logic saw_full;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!out_valid && w < 40);
                snap     = '{grp: out_grp, re: re, im: im};
                saw_full = !req_ready;
                n_tests++;
                if (out_valid !== 1'b1 || out_grp !== GRP_BITS'(3)) begin
                    n_fail++;
                    $display("FAIL b2b_first: got v %b grp %0d, required 1 3", out_valid, out_grp);
                end
                repeat (3) begin
                    @(negedge clk);
                    if (!req_ready) saw_full = 1'b1;
                    n_tests++;
                    if (out_valid !== 1'b1 || out_grp !== snap.grp ||
                        re !== snap.re || im !== snap.im) begin
                        n_fail++;
                        $display("FAIL b2b_hold: got v %b grp %0d, required 1 %0d with unchanged data",
                                 out_valid, out_grp, snap.grp);
                    end
                end
                n_tests++;
                if (!saw_full) begin
                    n_fail++;
                    $display("FAIL b2b_ready_drop: got req_ready 1 throughout stall, required 0");
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_q.size() != 3 || obs_q[0].grp !== GRP_BITS'(3) ||
            obs_q[1].grp !== GRP_BITS'(4) || obs_q[2].grp !== GRP_BITS'(5)) begin
            n_fail++;
            $display("FAIL b2b_order: got %0d beats first grps %0d %0d %0d, required 3 beats 3 4 5",
                     obs_q.size(), obs_q[0].grp, obs_q[1].grp, obs_q[2].grp);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e  = exp_q.pop_front();
            o  = obs_q.pop_front();
            b  = lane_diff(e, o);
            bl = (b < 0) ? 0 : b;
            n_tests++;
            if (o.grp !== e.grp || b >= 0) begin
                n_fail++;
                $display("FAIL b2b_beat: got grp %0d lane %0d re %0d im %0d, required grp %0d re %0d im %0d",
                         o.grp, bl, $signed(o.re[bl]), $signed(o.im[bl]), e.grp,
                         m_re(int'(e.grp), bl), m_im(int'(e.grp), bl, e.inv));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_sweep();
        exp_t e;
        obs_t o;
        int   b;
        int   bl;
        int   acc;
        int   dones;
        int   last_cyc;
        int   done_cyc;
        logic busy_ok;
        acc      = 0;
        dones    = 0;
        last_cyc = -1;
        done_cyc = -1;
        busy_ok  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        start_inv = 1'b1;
        for (int g = 0; g < NUM_GRP; g++)
            exp_q.push_back('{grp: GRP_BITS'(g), inv: 1'b1});
        @(posedge clk);
        #1 start = 1'b0;
        start_inv = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_busy: got busy %b, required 1", busy);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done_cyc >= 0) begin
                n_tests++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_after_done: got busy %b done %b, required 0 0", busy, done);
                end
                break;
            end
            if (out_valid && out_ready) begin
                acc++;
                if (acc == NUM_GRP) last_cyc = cyc;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                if (!busy) busy_ok = 1'b0;
            end
        end
        out_ready = 1'b1;
        n_tests++;
        if (acc != NUM_GRP || dones != 1) begin
            n_fail++;
            $display("FAIL sweep_beats: got %0d beats %0d done, required %0d beats 1 done",
                     acc, dones, NUM_GRP);
        end
        n_tests++;
        if (done_cyc != last_cyc + 1 || !busy_ok) begin
            n_fail++;
            $display("FAIL sweep_done_timing: got done at %0d busy_ok %b, required %0d 1",
                     done_cyc, busy_ok, last_cyc + 1);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL sweep_count: got %0d beats, required %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e  = exp_q.pop_front();
            o  = obs_q.pop_front();
            b  = lane_diff(e, o);
            bl = (b < 0) ? 0 : b;
            n_tests++;
            if (o.grp !== e.grp || b >= 0) begin
                n_fail++;
                $display("FAIL sweep_beat: got grp %0d lane %0d re %0d im %0d, required grp %0d re %0d im %0d",
                         o.grp, bl, $signed(o.re[bl]), $signed(o.im[bl]), e.grp,
                         m_re(int'(e.grp), bl), m_im(int'(e.grp), bl, e.inv));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        obs_t o;
        int   b;
        int   bl;
        int   dn;
        out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        start_inv = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out_valid, busy, done, req_ready} !== 4'b0000 ||
            out_grp !== '0 || re !== '0 || im !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got v/b/d/r %b%b%b%b grp %0d, required 0000 0",
                     out_valid, busy, done, req_ready, out_grp);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        n_tests++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d cycles with done/busy, required 0", dn);
        end
        @(posedge clk);
        #1 start = 1'b1;
        for (int g = 0; g < NUM_GRP; g++)
            exp_q.push_back('{grp: GRP_BITS'(g), inv: 1'b0});
        @(posedge clk);
        #1 start = 1'b0;
        dn = 0;
        for (int i = 0; i < 300 && dn == 0; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        n_tests++;
        if (dn != 1) begin
            n_fail++;
            $display("FAIL rstmid_resweep_done: got %0d done, required 1", dn);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rstmid_count: got %0d beats, required %0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e  = exp_q.pop_front();
            o  = obs_q.pop_front();
            b  = lane_diff(e, o);
            bl = (b < 0) ? 0 : b;
            n_tests++;
            if (o.grp !== e.grp || b >= 0) begin
                n_fail++;
                $display("FAIL rstmid_beat: got grp %0d lane %0d re %0d im %0d, required grp %0d re %0d im %0d",
                         o.grp, bl, $signed(o.re[bl]), $signed(o.im[bl]), e.grp,
                         m_re(int'(e.grp), bl), m_im(int'(e.grp), bl, e.inv));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_collision();
        exp_t e;
        obs_t o;
        int   b;
        int   bl;
        int   dn;
        out_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b1;
        req_grp = GRP_BITS'(7);
        req_inv = 1'b0;
        @(posedge clk);
        #1 req_grp = GRP_BITS'(9);
        start = 1'b1;
        start_inv = 1'b0;
        for (int g = 0; g < NUM_GRP; g++)
            exp_q.push_back('{grp: GRP_BITS'(g), inv: 1'b0});
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_ready: got req_ready %b with start, required 0", req_ready);
        end
        @(posedge clk);
        #1 start = 1'b0;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        start_inv = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_inv = 1'b0;
        dn = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) dn++;
            if (dn > 0 && !busy) break;
        end
        repeat (6) @(negedge clk);
        n_tests++;
        if (dn != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_done: got %0d done busy %b, required 1 done busy 0", dn, busy);
        end
        n_tests++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != NUM_GRP + 1) begin
            n_fail++;
            $display("FAIL coll_count: got %0d beats, required %0d",
                     obs_q.size(), NUM_GRP + 1);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e  = exp_q.pop_front();
            o  = obs_q.pop_front();
            b  = lane_diff(e, o);
            bl = (b < 0) ? 0 : b;
            n_tests++;
            if (o.grp !== e.grp || b >= 0) begin
                n_fail++;
                $display("FAIL coll_beat: got grp %0d lane %0d re %0d im %0d, required grp %0d re %0d im %0d",
                         o.grp, bl, $signed(o.re[bl]), $signed(o.im[bl]), e.grp,
                         m_re(int'(e.grp), bl), m_im(int'(e.grp), bl, e.inv));
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_quarter();
        test_back_to_back();
        test_sweep();
        test_reset_mid();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/twf_gen.md
TWF_GEN -- requirements
Module: twf_gen

Interface
REQ-001 Parameter LANES, default 16, twiddle pairs produced per output beat (power of 2, 2..64).
REQ-002 Parameter WIDTH, default 9, signed bit width of each re/im value (6..18).
REQ-003 Parameter GRP_BITS, default 5, width of the group index; NUM_GRP = 2**GRP_BITS.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  in  1  one clock; reset is asynchronous and active-high.
REQ-006 Port req_valid  in  1  external request for one group.
REQ-007 Port req_grp  in  GRP_BITS  group index of the request.
REQ-008 Port req_inv  in  1  1 = inverse-FFT twiddles (conjugate) for this request.
REQ-009 Port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-010 Port start  in  1  one-cycle pulse launching an automatic sweep of groups 0..NUM_GRP-1.
REQ-011 Port start_inv  in  1  conjugate flag applied to the whole sweep, sampled with start.
REQ-012 Port busy  out  1  high while a sweep is in progress.
REQ-013 Port done  out  1  one-cycle pulse when the last sweep beat is accepted at the output.
REQ-014 Port out_valid  out  1  re/im/out_grp hold a valid beat.
REQ-015 Port out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
REQ-016 Port out_grp  out  GRP_BITS  group index of the current output beat.
REQ-017 Port re  out  LANES x WIDTH signed  real parts, lane 0..LANES-1.
REQ-018 Port im  out  LANES x WIDTH signed  imaginary parts, lane 0..LANES-1.

Function
REQ-019 Table: N = 2*NUM_GRP*LANES; lane l of group g uses address a = g*LANES + l; S = 2**(WIDTH-2).
REQ-020 Forward value: re = round(S*cos(2*pi*a/N)), im = -round(S*sin(2*pi*a/N)), round half away from zero; |value| <= S, so no saturation is needed.
REQ-021 Inverse value (inv=1): re unchanged, im negated.
REQ-022 The table is constant and computed at elaboration; no run-time writes.
REQ-023 Pipeline: stage 1 registers grp/inv/tag; stage 2 registers re/im/out_grp/out_valid; the accepted-request-to-out_valid latency is exactly 2 cycles when no stall occurs.
REQ-024 Backpressure: when out_valid && !out_ready, all stages hold; stage 1 accepts new data only if stage 2 is empty, is draining, or stage 1 is empty. Full throughput is 1 beat per cycle.
REQ-025 Output stability: re/im/out_grp/out_valid do not change while out_valid && !out_ready.
REQ-026 FSM states: IDLE, SWEEP, DRAIN.
REQ-027 IDLE: req_ready = pipeline can accept; start moves the FSM to SWEEP, latches start_inv, and sets the sweep counter to 0.
REQ-028 SWEEP: req_ready = 0; the block issues an internal request with grp = counter each cycle the pipeline can accept, then increments the counter. After issuing NUM_GRP-1 it moves to DRAIN.
REQ-029 DRAIN: waits until the beat tagged as last is accepted at the output, pulses done in that same cycle (registered, visible the following edge), then moves to IDLE.
REQ-030 busy = 1 in SWEEP and DRAIN, and is also held through the done cycle.
REQ-031 start while busy is ignored. start and req_valid in the same IDLE cycle: start wins and the request is not accepted (req_ready = 0 that cycle).
REQ-032 External requests already in the pipeline when start arrives complete in order, ahead of the sweep beats.
REQ-033 Counter wrap: the counter is GRP_BITS wide; it does not wrap within a sweep because the FSM leaves SWEEP on the last index.

Reset
REQ-034 While rst is high: FSM = IDLE, counter = 0, all pipeline valid flags = 0, out_valid = 0, busy = 0, done = 0, req_ready = 0, re/im/out_grp = 0.
REQ-035 Reset asserted mid-sweep or mid-stall aborts immediately, with no done pulse. The first cycle after deassertion has req_ready = 1.

Verification (defaults LANES=16, WIDTH=9, GRP_BITS=5, S=128, N=1024)
REQ-036 req grp=0, inv=0, out_ready=1 -> 2 cycles later out_valid=1, out_grp=0, re[0]=128, im[0]=0, re[1]=128, im[1]=-1.
REQ-037 req grp=16 (a=256, quarter turn), inv=0 then inv=1 -> lane 0: re=0, im=-128; then re=0, im=+128.
REQ-038 back-to-back requests grp 3,4,5 with out_ready low for 4 cycles after the first beat -> beat 3 held stable, no loss or duplication; out_grp then 3,4,5 in order; req_ready drops while full.
REQ-039 start with start_inv=1 and random out_ready -> exactly 32 beats, out_grp 0..31 in order, all im negated vs forward, one done pulse on the last accept, busy low the cycle after.
REQ-040 rst pulse while in SWEEP at counter=10 -> all outputs 0, no done; a new start then yields a full 0..31 sweep.
REQ-041 start while busy, and start+req_valid in the same cycle -> start ignored while busy; the request is not accepted in the collision cycle.
